// File: rtl/wb_ep_window.sv
// wb_ep_window: Wishbone slave giving the CPU access to the USB core's endpoint
// buffers. Two access paths:
//   - a direct 512-word window (wb_addr[11]=1): writes go to TX, reads come from RX
//   - a pointer/data register pair with optional auto-increment (wb_addr[11]=0)
// Partial-strobe writes to buffer targets are acknowledged but dropped and
// counted in a saturating 8-bit error counter.
//
// Ports
//   clk, rst_n                          clk_wb domain clock, async active-low reset
//   wb_addr/wb_wdata/wb_wstb/wb_we      request address (byte), data, strobes, direction
//   wb_cyc/wb_stb                       request qualifiers
//   wb_rdata/wb_ack                     response data (0 unless acked), one-cycle ack
//   ep_tx_addr/ep_tx_data/ep_tx_we      TX buffer write port
//   ep_rx_addr/ep_rx_re/ep_rx_data      RX buffer read port, data READ_LAT cycles after re
module wb_ep_window #(
    parameter int EP_AW    = 9,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [16:0]      wb_addr,
    input  logic [31:0]      wb_wdata,
    input  logic [3:0]       wb_wstb,
    input  logic             wb_we,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    output logic [31:0]      wb_rdata,
    output logic             wb_ack,
    output logic [EP_AW-1:0] ep_tx_addr,
    output logic [31:0]      ep_tx_data,
    output logic             ep_tx_we,
    output logic [EP_AW-1:0] ep_rx_addr,
    output logic             ep_rx_re,
    input  logic [31:0]      ep_rx_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR      = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]       state;
    logic             cool;      // forces one idle cycle after every ack
    logic [EP_AW-1:0] ptr;
    logic             autoinc;
    logic [7:0]       err_cnt;
    logic [1:0]       lat_cnt;
    logic             rd_buf;    // pending read targets the RX buffer
    logic             rd_inc;    // pending read is an auto-incrementing DATA read
    logic [31:0]      rdata_q;
    logic [EP_AW-1:0] rx_addr_q;

    logic             accept, is_win, is_data, full, buf_acc;
    logic             wr_ok, wr_bad, rd_go;
    logic [1:0]       reg_off;
    logic [EP_AW-1:0] buf_idx;
    logic [31:0]      reg_rd_val;
    logic             unused_ok;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    assign unused_ok = ^wb_addr;

    always_comb begin
        // rst_n gates acceptance so the combinational read strobe is 0 in reset
        accept  = rst_n & (state == IDLE) & ~cool & wb_cyc & wb_stb;
        is_win  = wb_addr[11];
        reg_off = wb_addr[3:2];
        is_data = ~is_win & (reg_off == 2'd1);
        buf_acc = is_win | is_data;
        full    = (wb_wstb == 4'hf);
        buf_idx = is_win ? wb_addr[EP_AW+1:2] : ptr;
        wr_ok   = accept & wb_we & buf_acc & full;
        wr_bad  = accept & wb_we & buf_acc & ~full;
        rd_go   = accept & ~wb_we & buf_acc;

        reg_rd_val = '0;
        case (reg_off)
            2'd0: begin
                reg_rd_val[EP_AW-1:0] = ptr;
                reg_rd_val[31]        = autoinc;
            end
            2'd2: begin
                reg_rd_val[7:0]        = err_cnt;
                reg_rd_val[16 +: EP_AW] = ptr;
            end
            default: reg_rd_val = '0;
        endcase
    end

    // The RX read is issued in the request cycle itself; the address is
    // presented combinationally then and held from a register afterwards.
    assign ep_rx_re   = rd_go;
    assign ep_rx_addr = rd_go ? buf_idx : rx_addr_q;
    assign wb_ack     = (state == WR) | (state == ACK);
    assign wb_rdata   = (state == ACK) ? rdata_q : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cool       <= 1'b0;
            ptr        <= '0;
            autoinc    <= 1'b0;
            err_cnt    <= 8'd0;
            lat_cnt    <= 2'd0;
            rd_buf     <= 1'b0;
            rd_inc     <= 1'b0;
            rx_addr_q  <= '0;
            ep_tx_addr <= '0;
            ep_tx_data <= 32'd0;
            ep_tx_we   <= 1'b0;
        end else begin
            ep_tx_we <= wr_ok;
            if (wr_ok) begin
                ep_tx_addr <= buf_idx;
                ep_tx_data <= wb_wdata;
            end
            if (rd_go)
                rx_addr_q <= buf_idx;

            case (state)
                IDLE: begin
                    cool <= 1'b0;
                    if (accept) begin
                        if (wb_we) begin
                            // all write side effects commit on acceptance
                            state <= WR;
                            if (wr_bad)
                                err_cnt <= sat_inc(err_cnt);
                            else if (wr_ok && is_data && autoinc)
                                ptr <= ptr + 1'b1;
                            else if (!is_win && reg_off == 2'd0) begin
                                ptr     <= wb_wdata[EP_AW-1:0];
                                autoinc <= wb_wdata[31];
                            end else if (!is_win && reg_off == 2'd2 && wb_wdata[0])
                                err_cnt <= 8'd0;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= 2'(READ_LAT - 1);
                            rd_buf  <= buf_acc;
                            rd_inc  <= is_data & autoinc;
                        end
                    end
                end
                WR: begin
                    state <= IDLE;
                    cool  <= 1'b1;
                end
                RD_WAIT: begin
                    if (!wb_cyc)
                        state <= IDLE;
                    else if (lat_cnt == 2'd0)
                        state <= ACK;
                    else
                        lat_cnt <= lat_cnt - 2'd1;
                end
                default: begin
                    state <= IDLE;
                    cool  <= 1'b1;
                    if (rd_inc)
                        ptr <= ptr + 1'b1;
                end
            endcase
        end
    end

    // Read data holding register; only observable through wb_rdata in ACK.
    always_ff @(posedge clk) begin
        if (accept && !wb_we)
            rdata_q <= reg_rd_val;
        else if (state == RD_WAIT && lat_cnt == 2'd0 && rd_buf)
            rdata_q <= ep_rx_data;
    end

endmodule

// File: tb/tb_wb_ep_window.sv
// tb_wb_ep_window: directed bench for wb_ep_window. Instance u0 uses READ_LAT=1,
// u1 uses READ_LAT=2; each has its own bus qualifiers and RX read pipeline
// over a shared RX image.
module tb_wb_ep_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstb = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        tgt = 1'b0;

    logic [31:0] rdata0, rdata1, txd0, txd1, rxd0, rxd1;
    logic        ack0, ack1, txwe0, txwe1, re0, re1;
    logic [8:0]  txa0, txa1, rxa0, rxa1;
    logic [31:0] rxmem [512];
    logic [31:0] p0a, p1a, p1b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_ep_window #(.EP_AW(9), .READ_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .wb_addr(addr), .wb_wdata(wdata), .wb_wstb(wstb),
        .wb_we(we), .wb_cyc(cyc & ~tgt), .wb_stb(stb & ~tgt),
        .wb_rdata(rdata0), .wb_ack(ack0),
        .ep_tx_addr(txa0), .ep_tx_data(txd0), .ep_tx_we(txwe0),
        .ep_rx_addr(rxa0), .ep_rx_re(re0), .ep_rx_data(rxd0));

    wb_ep_window #(.EP_AW(9), .READ_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .wb_addr(addr), .wb_wdata(wdata), .wb_wstb(wstb),
        .wb_we(we), .wb_cyc(cyc & tgt), .wb_stb(stb & tgt),
        .wb_rdata(rdata1), .wb_ack(ack1),
        .ep_tx_addr(txa1), .ep_tx_data(txd1), .ep_tx_we(txwe1),
        .ep_rx_addr(rxa1), .ep_rx_re(re1), .ep_rx_data(rxd1));

    // RX buffer models: one register stage for u0, two for u1
    always @(posedge clk) begin
        if (re0) p0a <= rxmem[rxa0];
        if (re1) p1a <= rxmem[rxa1];
        p1b <= p1a;
    end
    assign rxd0 = p0a;
    assign rxd1 = p1b;

    wire        ack_t   = tgt ? ack1 : ack0;
    wire [31:0] rdata_t = tgt ? rdata1 : rdata0;
    wire        txwe_t  = tgt ? txwe1 : txwe0;
    wire [8:0]  txa_t   = tgt ? txa1 : txa0;
    wire [31:0] txd_t   = tgt ? txd1 : txd0;
    wire        re_t    = tgt ? re1 : re0;
    wire [8:0]  rxa_t   = tgt ? rxa1 : rxa0;

    // per-transaction observations
    int          lat;
    int          pulses;
    logic        re_c0;
    logic [8:0]  rxa_c0;
    logic [8:0]  seen_txa;
    logic [31:0] seen_txd;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; cycle 0 is the request cycle. lat=0 means no ack.
    task automatic xfer(input logic t, input logic w, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        tgt = t; we = w; addr = a; wdata = d; wstb = s; cyc = 1'b1; stb = 1'b1;
        lat = 0; pulses = 0; rd = 'x;
        #1;
        re_c0  = re_t;
        rxa_c0 = rxa_t;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (txwe_t) begin
                pulses++;
                seen_txa = txa_t;
                seen_txd = txd_t;
            end
            if (ack_t) begin
                lat = k;
                rd  = rdata_t;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (txwe_t) pulses++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rxmem[i] = 32'hC0DE_0000 | i;
        rxmem[7] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_txwe", {31'd0, txwe0}, 32'd0);
        chk("rst_txaddr", {23'd0, txa0}, 32'd0);
        chk("rst_rxre", {31'd0, re0}, 32'd0);
        rst_n = 1'b1;

        // direct window write
        xfer(1'b0, 1'b1, 17'h00814, 32'hA5A5_0001, 4'hf);
        chk("win_wr_lat", lat, 32'd1);
        chk("win_wr_pulses", pulses, 32'd1);
        chk("win_wr_addr", {23'd0, seen_txa}, 32'd5);
        chk("win_wr_data", seen_txd, 32'hA5A5_0001);

        // direct window read, READ_LAT=1
        xfer(1'b0, 1'b0, 17'h0081C, 32'd0, 4'hf);
        chk("win_rd_re_c0", {31'd0, re_c0}, 32'd1);
        chk("win_rd_addr", {23'd0, rxa_c0}, 32'd7);
        chk("win_rd_lat", lat, 32'd2);
        chk("win_rd_data", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rdata_idle", rdata0, 32'd0);

        // pointer streaming with wrap
        xfer(1'b0, 1'b1, 17'h00000, 32'h8000_01FE, 4'hf);
        xfer(1'b0, 1'b0, 17'h00000, 32'd0, 4'hf);
        chk("ptr_rd", rd, 32'h8000_01FE);
        xfer(1'b0, 1'b1, 17'h00004, 32'h11, 4'hf);
        chk("data_wr0_addr", {23'd0, seen_txa}, 32'h1FE);
        xfer(1'b0, 1'b1, 17'h00004, 32'h22, 4'hf);
        chk("data_wr1_addr", {23'd0, seen_txa}, 32'h1FF);
        xfer(1'b0, 1'b1, 17'h00004, 32'h33, 4'hf);
        chk("data_wr2_addr", {23'd0, seen_txa}, 32'h000);
        chk("data_wr2_data", seen_txd, 32'h33);
        xfer(1'b0, 1'b0, 17'h00008, 32'd0, 4'hf);
        chk("stat_after_wrap", rd, 32'h0001_0000);

        // DATA read with auto-increment
        xfer(1'b0, 1'b0, 17'h00004, 32'd0, 4'hf);
        chk("data_rd_val", rd, 32'hC0DE_0001);
        chk("data_rd_lat", lat, 32'd2);
        xfer(1'b0, 1'b0, 17'h00008, 32'd0, 4'hf);
        chk("stat_after_rd", rd, 32'h0002_0000);

        // partial writes
        xfer(1'b0, 1'b1, 17'h00820, 32'h1234_5678, 4'h3);
        chk("part_win_lat", lat, 32'd1);
        chk("part_win_pulses", pulses, 32'd0);
        xfer(1'b0, 1'b1, 17'h00004, 32'h1234_5678, 4'h7);
        chk("part_data_pulses", pulses, 32'd0);
        xfer(1'b0, 1'b0, 17'h00008, 32'd0, 4'hf);
        chk("stat_err2", rd, 32'h0002_0002);
        for (int i = 0; i < 298; i++)
            xfer(1'b0, 1'b1, 17'h00820, 32'h0, 4'h3);
        xfer(1'b0, 1'b0, 17'h00008, 32'd0, 4'hf);
        chk("stat_err_sat", rd, 32'h0002_00FF);
        xfer(1'b0, 1'b1, 17'h00008, 32'h1, 4'h1);
        xfer(1'b0, 1'b0, 17'h00008, 32'd0, 4'hf);
        chk("stat_clear", rd, 32'h0002_0000);

        // reserved register
        xfer(1'b0, 1'b1, 17'h0000C, 32'hFFFF_FFFF, 4'hf);
        chk("res_wr_lat", lat, 32'd1);
        xfer(1'b0, 1'b0, 17'h0000C, 32'd0, 4'hf);
        chk("res_rd", rd, 32'd0);

        // READ_LAT=2 instance: normal read, abort, then recovery
        xfer(1'b1, 1'b0, 17'h0081C, 32'd0, 4'hf);
        chk("l2_rd_lat", lat, 32'd3);
        chk("l2_rd_data", rd, 32'hDEAD_BEEF);
        xfer(1'b1, 1'b1, 17'h00000, 32'h8000_0010, 4'hf);
        @(negedge clk);
        tgt = 1'b1; we = 1'b0; addr = 17'h00004; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        chk("abort_c1_ack", {31'd0, ack1}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack1) pulses++;
        end
        chk("abort_no_ack", pulses, 32'd0);
        xfer(1'b1, 1'b0, 17'h00000, 32'd0, 4'hf);
        chk("abort_ptr", rd, 32'h8000_0010);
        xfer(1'b1, 1'b0, 17'h00004, 32'd0, 4'hf);
        chk("after_abort_data", rd, 32'hC0DE_0010);
        chk("after_abort_lat", lat, 32'd3);
        xfer(1'b1, 1'b0, 17'h00000, 32'd0, 4'hf);
        chk("after_abort_ptr", rd, 32'h8000_0011);

        // reset during RD_WAIT on u0
        @(negedge clk);
        tgt = 1'b0; we = 1'b0; addr = 17'h0081C; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ack", {31'd0, ack0}, 32'd0);
        chk("mrst_rdata", rdata0, 32'd0);
        chk("mrst_rxre", {31'd0, re0}, 32'd0);
        chk("mrst_rxaddr", {23'd0, rxa0}, 32'd0);
        chk("mrst_txdata", txd0, 32'd0);
        chk("mrst_txwe", {31'd0, txwe0}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 1'b0, 17'h00000, 32'd0, 4'hf);
        chk("mrst_ptr", rd, 32'd0);
        chk("mrst_ptr_lat", lat, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
